// File: rtl/pat_seq_pkg.sv
// ---------------------------------------------------------------------------
// pat_seq_pkg
//   Shared definitions for the pattern sequencer buffer:
//     - per-slot field index map (drive, sense, delay and tweak fields)
//     - field_count(): slot field count as a function of the tweak count
//     - off-state bit values for the pad drivers
//     - phase_e: meaning of the registered pwm level
// ---------------------------------------------------------------------------
package pat_seq_pkg;

  // Fixed low part of the field map.
  localparam int F_PDRIVE = 0;
  localparam int F_NDRIVE = 1;
  localparam int F_PSENSE = 2;
  localparam int F_PDELAY = 3;
  localparam int F_PTWEAK = 4;

  // The N-side sense/delay/tweak block follows the P-side tweaks, so its
  // position depends on the tweak count.
  function automatic int f_nsense(input int num_tweaks);
    return F_PTWEAK + num_tweaks;
  endfunction

  function automatic int f_ndelay(input int num_tweaks);
    return F_PTWEAK + num_tweaks + 1;
  endfunction

  function automatic int f_ntweak(input int num_tweaks);
    return F_PTWEAK + num_tweaks + 2;
  endfunction

  // Two drive fields plus a sense, delay and tweak group per side.
  function automatic int field_count(input int num_tweaks);
    return 2 + 2 * (2 + num_tweaks);
  endfunction

  // Off levels: p-side drivers are active-low, n-side active-high.
  localparam logic P_OFF_BIT     = 1'b1;
  localparam logic N_OFF_BIT     = 1'b0;
  localparam logic TWEAK_OFF_BIT = 1'b0;

  typedef enum logic {
    PHASE_N = 1'b0,
    PHASE_P = 1'b1
  } phase_e;

endpackage : pat_seq_pkg

// File: rtl/pat_slot_sequencer.sv
// ---------------------------------------------------------------------------
// pat_slot_sequencer
//   Timing core of the pattern sequencer: pwm edge detect, dwell counter,
//   slot counter and (optionally) the dead-time counter.
//   Optional feature macro: PATSEQ_DEADTIME_EN (adds DEAD_CYCLES).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_pwm         phase input, already synchronous to clk
//   i_dwell       slot dwell minus one (0 = advance every cycle)
//   o_pwm_q       registered pwm level (the phase being driven)
//   o_edge        pwm differs from its registered copy this cycle
//   o_slot        slot currently selected
//   o_drive_en    0 while the dead-time window blanks the drivers
// ---------------------------------------------------------------------------
module pat_slot_sequencer
  import pat_seq_pkg::*;
#(
  parameter int NUM_BUFS    = 8,
  parameter int DWELL_W     = 4,
`ifdef PATSEQ_DEADTIME_EN
  parameter int DEAD_CYCLES = 2,
`endif
  localparam int BUF_AW     = $clog2(NUM_BUFS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pwm,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic              o_pwm_q,
  output logic              o_edge,
  output logic [BUF_AW-1:0] o_slot,
  output logic              o_drive_en
);

  localparam logic [BUF_AW-1:0] LAST_SLOT = BUF_AW'(NUM_BUFS - 1);

  logic               r_pwm_q;
  logic [BUF_AW-1:0]  r_slot;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               w_edge;
  logic               w_drive_en;

  assign w_edge = i_pwm ^ r_pwm_q;

`ifdef PATSEQ_DEADTIME_EN
  localparam int DEAD_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);

  logic [DEAD_W-1:0] r_dead_cnt;

  // Reloaded on every edge, so a toggle during the blanking window
  // restarts the full dead time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dead_cnt <= '0;
    end else if (w_edge) begin
      r_dead_cnt <= DEAD_W'(DEAD_CYCLES);
    end else if (r_dead_cnt != '0) begin
      r_dead_cnt <= r_dead_cnt - 1'b1;
    end
  end

  assign w_drive_en = (r_dead_cnt == '0);
`else
  assign w_drive_en = 1'b1;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every comparison below sees the pre-edge register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_q     <= 1'b0;
      r_slot      <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_pwm_q <= i_pwm;
      if (w_edge) begin
        r_slot      <= '0;
        r_dwell_cnt <= '0;
      end else if (w_drive_en) begin
        // Equality compare: if dwell is lowered below the running count the
        // counter wraps through 2^DWELL_W before matching again.
        if (r_dwell_cnt == i_dwell) begin
          r_dwell_cnt <= '0;
          if (r_slot != LAST_SLOT) begin
            r_slot <= r_slot + 1'b1;
          end
        end else begin
          r_dwell_cnt <= r_dwell_cnt + 1'b1;
        end
      end
    end
  end

  assign o_pwm_q    = r_pwm_q;
  assign o_edge     = w_edge;
  assign o_slot     = r_slot;
  assign o_drive_en = w_drive_en;

endmodule : pat_slot_sequencer

// File: rtl/pattern_sequencer_buffer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer_buffer
//   Double-banked pattern store between the pat processor write port and the
//   pad drivers. Writes go to a shadow bank; an armed commit copies shadow to
//   active in one cycle on a pwm edge. After each edge the slots are stepped
//   with a programmable dwell and the active bank drives p/n/tweak outputs.
//   Optional feature macro: PATSEQ_DEADTIME_EN (driver blanking after edges).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   pwm                          phase input (1 = high-driving phase)
//   dwell                        slot dwell minus one
//   wr_en/wr_buf/wr_field/wr_data  shadow write port
//   commit_req, commit_pending   commit request / armed indication
//   rd_buf/rd_field/rd_active    readback address and bank select
//   rd_data                      registered readback data
//   slot_idx                     slot currently driving
//   p_drive, n_drive             pad drives
//   tweak_sense, tweak_delay     tweak controls of the current phase
//   tweak_drive                  tweak k at [k*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module pattern_sequencer_buffer
  import pat_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_BUFS    = 8,
  parameter int NUM_TWEAKS  = 8,
  parameter int DWELL_W     = 4,
`ifdef PATSEQ_DEADTIME_EN
  parameter int DEAD_CYCLES = 2,
`endif
  localparam int FIELD_COUNT = field_count(NUM_TWEAKS),
  localparam int BUF_AW      = $clog2(NUM_BUFS),
  localparam int FIELD_AW    = $clog2(FIELD_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pwm,
  input  logic [DWELL_W-1:0]          dwell,
  input  logic                        wr_en,
  input  logic [BUF_AW-1:0]           wr_buf,
  input  logic [FIELD_AW-1:0]         wr_field,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        commit_req,
  output logic                        commit_pending,
  input  logic [BUF_AW-1:0]           rd_buf,
  input  logic [FIELD_AW-1:0]         rd_field,
  input  logic                        rd_active,
  output logic [WIDTH-1:0]            rd_data,
  output logic [BUF_AW-1:0]           slot_idx,
  output logic [WIDTH-1:0]            p_drive,
  output logic [WIDTH-1:0]            n_drive,
  output logic [WIDTH-1:0]            tweak_sense,
  output logic [WIDTH-1:0]            tweak_delay,
  output logic [NUM_TWEAKS*WIDTH-1:0] tweak_drive
);

  localparam int F_NSENSE = f_nsense(NUM_TWEAKS);
  localparam int F_NDELAY = f_ndelay(NUM_TWEAKS);
  localparam int F_NTWEAK = f_ntweak(NUM_TWEAKS);

  logic [WIDTH-1:0] r_shadow [NUM_BUFS][FIELD_COUNT];
  logic [WIDTH-1:0] r_active [NUM_BUFS][FIELD_COUNT];

  logic                        r_commit_pending;
  logic [WIDTH-1:0]            r_rd_data;
  logic [BUF_AW-1:0]           r_slot_idx;
  logic [WIDTH-1:0]            r_p_drive;
  logic [WIDTH-1:0]            r_n_drive;
  logic [WIDTH-1:0]            r_tweak_sense;
  logic [WIDTH-1:0]            r_tweak_delay;
  logic [NUM_TWEAKS*WIDTH-1:0] r_tweak_drive;

  logic                        w_pwm_q;
  logic                        w_edge;
  logic [BUF_AW-1:0]           w_slot;
  logic                        w_drive_en;
  logic                        w_wr_ok;
  logic                        w_rd_ok;
  logic                        w_commit;
  logic [WIDTH-1:0]            w_p_drive;
  logic [WIDTH-1:0]            w_n_drive;
  logic [WIDTH-1:0]            w_tweak_sense;
  logic [WIDTH-1:0]            w_tweak_delay;
  logic [NUM_TWEAKS*WIDTH-1:0] w_tweak_drive;

  pat_slot_sequencer #(
    .NUM_BUFS    (NUM_BUFS),
`ifdef PATSEQ_DEADTIME_EN
    .DEAD_CYCLES (DEAD_CYCLES),
`endif
    .DWELL_W     (DWELL_W)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pwm      (pwm),
    .i_dwell    (dwell),
    .o_pwm_q    (w_pwm_q),
    .o_edge     (w_edge),
    .o_slot     (w_slot),
    .o_drive_en (w_drive_en)
  );

  // Index range checks are done at 32 bits so non-power-of-two sizes work.
  assign w_wr_ok  = wr_en && (int'(wr_buf) < NUM_BUFS) && (int'(wr_field) < FIELD_COUNT);
  assign w_rd_ok  = (int'(rd_buf) < NUM_BUFS) && (int'(rd_field) < FIELD_COUNT);
  // A request coinciding with the edge commits at that same edge.
  assign w_commit = w_edge && (r_commit_pending || commit_req);

  // NOTE: both banks are cleared by reset because the drivers read the
  // active bank straight after reset; this forces flop storage, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
    end else begin
      // The copy reads pre-edge shadow, so a same-cycle write stays in
      // shadow only.
      if (w_commit) begin
        r_active <= r_shadow;
      end
      if (w_wr_ok) begin
        r_shadow[wr_buf][wr_field] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_pending <= 1'b0;
    end else if (w_commit) begin
      r_commit_pending <= 1'b0;
    end else if (commit_req) begin
      r_commit_pending <= 1'b1;
    end
  end

  // Readback sees the bank contents before any write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (!w_rd_ok) begin
      r_rd_data <= '0;
    end else if (rd_active) begin
      r_rd_data <= r_active[rd_buf][rd_field];
    end else begin
      r_rd_data <= r_shadow[rd_buf][rd_field];
    end
  end

  // NOTE: every output of this block is given its off value first, so no
  // path through the branches can leave one unassigned and infer a latch.
  always_comb begin
    w_p_drive     = {WIDTH{P_OFF_BIT}};
    w_n_drive     = {WIDTH{N_OFF_BIT}};
    w_tweak_sense = {WIDTH{TWEAK_OFF_BIT}};
    w_tweak_delay = {WIDTH{TWEAK_OFF_BIT}};
    w_tweak_drive = {(NUM_TWEAKS*WIDTH){TWEAK_OFF_BIT}};
    if (w_drive_en) begin
      if (phase_e'(w_pwm_q) == PHASE_P) begin
        w_p_drive     = r_active[w_slot][F_PDRIVE];
        w_tweak_sense = r_active[w_slot][F_PSENSE];
        w_tweak_delay = r_active[w_slot][F_PDELAY];
        for (int k = 0; k < NUM_TWEAKS; k++) begin
          w_tweak_drive[k*WIDTH +: WIDTH] = r_active[w_slot][F_PTWEAK + k];
        end
      end else begin
        w_n_drive     = r_active[w_slot][F_NDRIVE];
        w_tweak_sense = r_active[w_slot][F_NSENSE];
        w_tweak_delay = r_active[w_slot][F_NDELAY];
        for (int k = 0; k < NUM_TWEAKS; k++) begin
          w_tweak_drive[k*WIDTH +: WIDTH] = r_active[w_slot][F_NTWEAK + k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_idx    <= '0;
      r_p_drive     <= {WIDTH{P_OFF_BIT}};
      r_n_drive     <= {WIDTH{N_OFF_BIT}};
      r_tweak_sense <= '0;
      r_tweak_delay <= '0;
      r_tweak_drive <= '0;
    end else begin
      r_slot_idx    <= w_slot;
      r_p_drive     <= w_p_drive;
      r_n_drive     <= w_n_drive;
      r_tweak_sense <= w_tweak_sense;
      r_tweak_delay <= w_tweak_delay;
      r_tweak_drive <= w_tweak_drive;
    end
  end

  assign commit_pending = r_commit_pending;
  assign rd_data        = r_rd_data;
  assign slot_idx       = r_slot_idx;
  assign p_drive        = r_p_drive;
  assign n_drive        = r_n_drive;
  assign tweak_sense    = r_tweak_sense;
  assign tweak_delay    = r_tweak_delay;
  assign tweak_drive    = r_tweak_drive;

endmodule : pattern_sequencer_buffer
